// File: rtl/fetch_order_monitor.sv
// In-order request/response scoreboard for a cache read port: queues issued
// addresses, checks each response against the oldest one, and keeps counters.
module fetch_order_monitor #(
  parameter int ADDRESS_BITS = 12,
  parameter int DEPTH = 4,
  parameter int CNT_BITS = 32,
  parameter logic [ADDRESS_BITS-1:0] END_PC = 12'h0B0
) (
  input  logic                      clock,
  input  logic                      reset,
  // A valid is a single-cycle event: no ready, the monitor never stalls the port.
  input  logic                      req_valid,
  input  logic [ADDRESS_BITS-1:0]   req_addr,
  input  logic                      rsp_valid,
  input  logic [ADDRESS_BITS-1:0]   rsp_addr,
  input  logic [ADDRESS_BITS-1:0]   mon_pc,
  output logic [$clog2(DEPTH):0]    outstanding,
  output logic                      full,
  output logic                      empty,
  output logic                      err_overflow,
  output logic                      err_underflow,
  output logic                      err_mismatch,
  output logic                      err_pulse,
  output logic [ADDRESS_BITS-1:0]   err_expected,
  output logic [ADDRESS_BITS-1:0]   err_got,
  output logic [CNT_BITS-1:0]       cycle_count,
  output logic [CNT_BITS-1:0]       req_count,
  output logic [CNT_BITS-1:0]       rsp_count,
  output logic                      done,
  output logic [CNT_BITS-1:0]       done_cycles
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int OCC_BITS = PTR_BITS + 1;
  localparam logic [OCC_BITS-1:0] DEPTH_OCC = OCC_BITS'(DEPTH);
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

  logic [ADDRESS_BITS-1:0] mem [DEPTH];
  logic [PTR_BITS-1:0]     rd_ptr;
  logic [PTR_BITS-1:0]     wr_ptr;

  logic                    is_empty;
  logic                    is_full;
  logic                    bypass;
  logic                    pop;
  logic                    push;
  logic                    accepted;
  logic                    rsp_checked;
  logic                    mismatch;
  logic                    underflow;
  logic                    overflow;
  logic [ADDRESS_BITS-1:0] expected;
  logic [OCC_BITS-1:0]     occ_next;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_BITS'(1);
  endfunction

  always_comb begin
    is_empty    = (outstanding == '0);
    is_full     = (outstanding == DEPTH_OCC);
    // An empty queue with a same-cycle request checks the response against it directly.
    bypass      = is_empty && req_valid && rsp_valid;
    expected    = is_empty ? req_addr : mem[rd_ptr];
    pop         = rsp_valid && !is_empty;
    rsp_checked = pop || bypass;
    mismatch    = rsp_checked && (rsp_addr != expected);
    underflow   = rsp_valid && is_empty && !req_valid;
    overflow    = req_valid && is_full && !pop;
    accepted    = req_valid && !overflow;
    push        = accepted && !bypass;
    occ_next    = outstanding + OCC_BITS'(push) - OCC_BITS'(pop);
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= req_addr;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      outstanding   <= '0;
      full          <= 1'b0;
      empty         <= 1'b1;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_mismatch  <= 1'b0;
      err_pulse     <= 1'b0;
      err_expected  <= '0;
      err_got       <= '0;
      cycle_count   <= '0;
      req_count     <= '0;
      rsp_count     <= '0;
      done          <= 1'b0;
      done_cycles   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_BITS'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_BITS'(1);
      outstanding <= occ_next;
      full        <= (occ_next == DEPTH_OCC);
      empty       <= (occ_next == '0);

      if (overflow)  err_overflow  <= 1'b1;
      if (underflow) err_underflow <= 1'b1;
      if (mismatch) begin
        err_mismatch <= 1'b1;
        if (!err_mismatch) begin
          err_expected <= expected;
          err_got      <= rsp_addr;
        end
      end
      err_pulse <= overflow || underflow || mismatch;

      cycle_count <= sat_inc(cycle_count);
      if (accepted)  req_count <= sat_inc(req_count);
      if (rsp_valid) rsp_count <= sat_inc(rsp_count);

      if (!done && (mon_pc == END_PC)) begin
        done        <= 1'b1;
        done_cycles <= cycle_count;
      end
    end
  end

endmodule

// File: tb/tb_fetch_order_monitor.sv
// Directed bench for fetch_order_monitor: inputs change on the falling edge,
// outputs are compared on the falling edge after each rising edge.
module tb_fetch_order_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [11:0] req_addr = '0;
  logic        rsp_valid = 1'b0;
  logic [11:0] rsp_addr = '0;
  logic [11:0] mon_pc = '0;
  logic [2:0]  outstanding;
  logic        full, empty;
  logic        err_overflow, err_underflow, err_mismatch, err_pulse;
  logic [11:0] err_expected, err_got;
  logic [31:0] cycle_count, req_count, rsp_count, done_cycles;
  logic        done;

  int checks = 0;
  int passes = 0;

  fetch_order_monitor #(
    .ADDRESS_BITS(12), .DEPTH(4), .CNT_BITS(32), .END_PC(12'h0B0)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_addr(rsp_addr),
    .mon_pc(mon_pc),
    .outstanding(outstanding), .full(full), .empty(empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .err_mismatch(err_mismatch), .err_pulse(err_pulse),
    .err_expected(err_expected), .err_got(err_got),
    .cycle_count(cycle_count), .req_count(req_count), .rsp_count(rsp_count),
    .done(done), .done_cycles(done_cycles)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; req_valid = 1'b0; rsp_valid = 1'b0; mon_pc = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  // driver: one cycle of request/response activity, valids dropped afterwards
  task automatic step(input logic rv, input logic [11:0] ra,
                      input logic sv, input logic [11:0] sa);
    req_valid = rv; req_addr = ra; rsp_valid = sv; rsp_addr = sa;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0; rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (outstanding !== 3'd0) $display("FAIL rst_outstanding got %0d want 0", outstanding); else passes++;
    checks++; if (empty !== 1'b1 || full !== 1'b0) $display("FAIL rst_empty_full got %b%b want 10", empty, full); else passes++;
    checks++; if ({err_overflow, err_underflow, err_mismatch, err_pulse, done} !== 5'b0)
      $display("FAIL rst_flags got %b want 00000", {err_overflow, err_underflow, err_mismatch, err_pulse, done}); else passes++;
    checks++; if ({cycle_count, req_count, rsp_count, done_cycles} !== 128'b0 || {err_expected, err_got} !== 24'b0)
      $display("FAIL rst_counters cyc=%0d req=%0d rsp=%0d dc=%0d want all 0", cycle_count, req_count, rsp_count, done_cycles); else passes++;
  endtask

  task automatic test_in_order();
    logic [2:0] exp_occ [6];
    exp_occ = '{3'd1, 3'd2, 3'd3, 3'd2, 3'd1, 3'd0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i < 3) step(1'b1, 12'(i * 4), 1'b0, '0);
      else       step(1'b0, '0, 1'b1, 12'((i - 3) * 4));
      checks++; if (outstanding !== exp_occ[i]) $display("FAIL inorder_occ[%0d] got %0d want %0d", i, outstanding, exp_occ[i]); else passes++;
    end
    checks++; if ({err_overflow, err_underflow, err_mismatch} !== 3'b0) $display("FAIL inorder_errs got %b want 000", {err_overflow, err_underflow, err_mismatch}); else passes++;
    checks++; if (req_count !== 32'd3 || rsp_count !== 32'd3) $display("FAIL inorder_counts req=%0d rsp=%0d want 3/3", req_count, rsp_count); else passes++;
    checks++; if (empty !== 1'b1) $display("FAIL inorder_empty got %b want 1", empty); else passes++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 12'(i * 4), 1'b0, '0);
    checks++; if (full !== 1'b1 || outstanding !== 3'd4) $display("FAIL ovf_full got full=%b occ=%0d want 1/4", full, outstanding); else passes++;
    checks++; if (err_overflow !== 1'b0) $display("FAIL ovf_early got %b want 0", err_overflow); else passes++;
    step(1'b1, 12'h010, 1'b0, '0);
    checks++; if (err_overflow !== 1'b1 || err_pulse !== 1'b1) $display("FAIL ovf_flag got ovf=%b pulse=%b want 1/1", err_overflow, err_pulse); else passes++;
    checks++; if (req_count !== 32'd4 || outstanding !== 3'd4) $display("FAIL ovf_dropped req=%0d occ=%0d want 4/4", req_count, outstanding); else passes++;
    step(1'b0, '0, 1'b0, '0);
    checks++; if (err_pulse !== 1'b0 || err_overflow !== 1'b1) $display("FAIL ovf_pulse_once pulse=%b ovf=%b want 0/1", err_pulse, err_overflow); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp_q [$];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 12'(i * 4), 1'b0, '0);
      exp_q.push_back(12'(i * 4));
    end
    step(1'b1, 12'h010, 1'b1, exp_q.pop_front());
    exp_q.push_back(12'h010);
    checks++; if (err_overflow !== 1'b0 || outstanding !== 3'd4) $display("FAIL b2b_full_push ovf=%b occ=%0d want 0/4", err_overflow, outstanding); else passes++;
    checks++; if (req_count !== 32'd5) $display("FAIL b2b_req_count got %0d want 5", req_count); else passes++;
    while (exp_q.size() > 0) step(1'b0, '0, 1'b1, exp_q.pop_front());
    checks++; if (err_mismatch !== 1'b0 || outstanding !== 3'd0) $display("FAIL b2b_wrap mm=%b occ=%0d want 0/0", err_mismatch, outstanding); else passes++;
    checks++; if (rsp_count !== 32'd5) $display("FAIL b2b_rsp_count got %0d want 5", rsp_count); else passes++;
  endtask

  task automatic test_mismatch();
    do_reset();
    step(1'b1, 12'h020, 1'b0, '0);
    step(1'b0, '0, 1'b1, 12'h024);
    checks++; if (err_mismatch !== 1'b1 || err_pulse !== 1'b1) $display("FAIL mm_flag mm=%b pulse=%b want 1/1", err_mismatch, err_pulse); else passes++;
    checks++; if (err_expected !== 12'h020 || err_got !== 12'h024) $display("FAIL mm_capture exp=%h got=%h want 020/024", err_expected, err_got); else passes++;
    checks++; if (outstanding !== 3'd0) $display("FAIL mm_popped got %0d want 0", outstanding); else passes++;
    step(1'b1, 12'h040, 1'b0, '0);
    step(1'b0, '0, 1'b1, 12'h044);
    checks++; if (err_expected !== 12'h020 || err_got !== 12'h024) $display("FAIL mm_hold exp=%h got=%h want 020/024", err_expected, err_got); else passes++;
    checks++; if (err_pulse !== 1'b1) $display("FAIL mm_second_pulse got %b want 1", err_pulse); else passes++;
  endtask

  task automatic test_underflow_bypass();
    do_reset();
    step(1'b0, '0, 1'b1, 12'h100);
    checks++; if (err_underflow !== 1'b1 || err_pulse !== 1'b1) $display("FAIL uf_flag uf=%b pulse=%b want 1/1", err_underflow, err_pulse); else passes++;
    checks++; if (rsp_count !== 32'd1 || outstanding !== 3'd0) $display("FAIL uf_counts rsp=%0d occ=%0d want 1/0", rsp_count, outstanding); else passes++;
    do_reset();
    step(1'b1, 12'h030, 1'b1, 12'h030);
    checks++; if ({err_overflow, err_underflow, err_mismatch, err_pulse} !== 4'b0)
      $display("FAIL bypass_errs got %b want 0000", {err_overflow, err_underflow, err_mismatch, err_pulse}); else passes++;
    checks++; if (outstanding !== 3'd0 || empty !== 1'b1) $display("FAIL bypass_occ occ=%0d empty=%b want 0/1", outstanding, empty); else passes++;
    step(1'b1, 12'h034, 1'b1, 12'h038);
    checks++; if (err_mismatch !== 1'b1 || err_expected !== 12'h034 || err_got !== 12'h038)
      $display("FAIL bypass_mm mm=%b exp=%h got=%h want 1/034/038", err_mismatch, err_expected, err_got); else passes++;
  endtask

  task automatic test_done();
    do_reset();
    repeat (100) @(posedge clock);
    @(negedge clock);
    mon_pc = 12'h0B0;
    @(posedge clock);
    @(negedge clock);
    mon_pc = '0;
    checks++; if (done !== 1'b1 || done_cycles !== 32'd100) $display("FAIL done_first done=%b dc=%0d want 1/100", done, done_cycles); else passes++;
    checks++; if (cycle_count !== 32'd101) $display("FAIL done_cycle_count got %0d want 101", cycle_count); else passes++;
    repeat (19) @(posedge clock);
    @(negedge clock);
    mon_pc = 12'h0B0;
    @(posedge clock);
    @(negedge clock);
    mon_pc = '0;
    checks++; if (done !== 1'b1 || done_cycles !== 32'd100) $display("FAIL done_second done=%b dc=%0d want 1/100", done, done_cycles); else passes++;
    // mid-queue reset with an error already latched
    step(1'b0, '0, 1'b1, 12'h200);
    for (int i = 0; i < 3; i++) step(1'b1, 12'(i * 4), 1'b0, '0);
    checks++; if (outstanding !== 3'd3 || err_underflow !== 1'b1) $display("FAIL pre_rst occ=%0d uf=%b want 3/1", outstanding, err_underflow); else passes++;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    checks++; if (outstanding !== 3'd0 || empty !== 1'b1 || full !== 1'b0) $display("FAIL midrst_occ occ=%0d empty=%b full=%b want 0/1/0", outstanding, empty, full); else passes++;
    checks++; if ({err_overflow, err_underflow, err_mismatch, err_pulse, done} !== 5'b0)
      $display("FAIL midrst_flags got %b want 00000", {err_overflow, err_underflow, err_mismatch, err_pulse, done}); else passes++;
    checks++; if ({cycle_count, req_count, rsp_count, done_cycles} !== 128'b0)
      $display("FAIL midrst_counters cyc=%0d req=%0d rsp=%0d dc=%0d want all 0", cycle_count, req_count, rsp_count, done_cycles); else passes++;
    reset = 1'b0;
    step(1'b0, '0, 1'b1, 12'h000);
    checks++; if (err_underflow !== 1'b1) $display("FAIL midrst_discard uf=%b want 1", err_underflow); else passes++;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_overflow();
    test_back_to_back();
    test_mismatch();
    test_underflow_bypass();
    test_done();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
